// File: rtl/demap_frame_ctrl.sv
// Frame-alignment controller: FAS hunt, HUNT/PRESYNC/SYNC lock and row/column sequencing.
// Optional statistics counters enabled by defining DEMAP_FRAME_STATS_EN.
module demap_frame_ctrl #(
    parameter int unsigned MISS_LIMIT = 4,
    parameter logic [7:0]  FAS_A      = 8'hF6,
    parameter logic [7:0]  FAS_B      = 8'h28
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_line_data,
    input  logic        i_line_data_valid,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_in_sync,
`ifdef DEMAP_FRAME_STATS_EN
    output logic [15:0] o_fas_err_cnt,
    output logic [15:0] o_lof_cnt,
`endif
    output logic        o_lof
);

    localparam logic [10:0] LAST_COL = 11'd1040;

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t          state_q, state_d;
    logic [4:0][7:0] sr_q;
    logic [1:0]      nrow_q, nrow_d;
    logic [10:0]     ncol_q, ncol_d;
    logic [2:0]      miss_q, miss_d;
    logic [2:0]      miss_inc;
    logic [1:0]      row_d;
    logic [10:0]     col_d;
    logic            lof_d;
    logic            fas_match;
    logic            at_fas;

    // sr_q[4] is the oldest byte, sr_q[0] the most recent
    assign fas_match = (sr_q[4] == FAS_A) && (sr_q[3] == FAS_A) && (sr_q[2] == FAS_A) &&
                       (sr_q[1] == FAS_B) && (sr_q[0] == FAS_B) && (i_line_data == FAS_B);
    assign at_fas    = (nrow_q == 2'd0) && (ncol_q == 11'd5);
    assign miss_inc  = miss_q + 3'd1;

    always_comb begin
        state_d = state_q;
        nrow_d  = nrow_q;
        ncol_d  = ncol_q;
        miss_d  = miss_q;
        row_d   = o_row_cnt;
        col_d   = o_col_cnt;
        lof_d   = 1'b0;
        if (i_line_data_valid) begin
            row_d = nrow_q;
            col_d = ncol_q;
            if (ncol_q == LAST_COL) begin
                ncol_d = '0;
                nrow_d = nrow_q + 2'd1;
            end else begin
                ncol_d = ncol_q + 11'd1;
            end
            case (state_q)
                HUNT: begin
                    if (fas_match) begin
                        row_d   = 2'd0;
                        col_d   = 11'd5;
                        nrow_d  = 2'd0;
                        ncol_d  = 11'd6;
                        state_d = PRESYNC;
                    end
                end
                PRESYNC: begin
                    // A mismatching byte cannot also satisfy the hunt comparison, so plain HUNT suffices
                    if (at_fas) begin
                        if (fas_match) begin
                            state_d = SYNC;
                            miss_d  = '0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                SYNC: begin
                    if (at_fas) begin
                        if (fas_match) begin
                            miss_d = '0;
                        end else if (miss_inc == 3'(MISS_LIMIT)) begin
                            miss_d  = '0;
                            lof_d   = 1'b1;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

`ifdef DEMAP_FRAME_STATS_EN
    logic fas_err;
    assign fas_err = i_line_data_valid && at_fas && (state_q != HUNT) && !fas_match;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= HUNT;
            sr_q               <= '0;
            nrow_q             <= '0;
            ncol_q             <= '0;
            miss_q             <= '0;
            o_frame_data       <= '0;
            o_frame_data_valid <= 1'b0;
            o_row_cnt          <= '0;
            o_col_cnt          <= '0;
            o_in_sync          <= 1'b0;
            o_lof              <= 1'b0;
`ifdef DEMAP_FRAME_STATS_EN
            o_fas_err_cnt      <= '0;
            o_lof_cnt          <= '0;
`endif
        end else begin
            state_q            <= state_d;
            nrow_q             <= nrow_d;
            ncol_q             <= ncol_d;
            miss_q             <= miss_d;
            if (i_line_data_valid) begin
                sr_q <= {sr_q[3:0], i_line_data};
            end
            o_frame_data       <= i_line_data;
            o_frame_data_valid <= i_line_data_valid && (state_q == SYNC);
            o_row_cnt          <= row_d;
            o_col_cnt          <= col_d;
            o_in_sync          <= (state_d == SYNC);
            o_lof              <= lof_d;
`ifdef DEMAP_FRAME_STATS_EN
            if (fas_err && (o_fas_err_cnt != '1)) begin
                o_fas_err_cnt <= o_fas_err_cnt + 16'd1;
            end
            if (lof_d && (o_lof_cnt != '1)) begin
                o_lof_cnt <= o_lof_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_demap_frame_ctrl.sv
// Directed testbench for demap_frame_ctrl: acquisition, PRESYNC drop, LOF, gapped input, mid-frame reset.
module tb_demap_frame_ctrl;

    localparam logic [7:0] FAS_A = 8'hF6;
    localparam logic [7:0] FAS_B = 8'h28;
    localparam int FRAME = 4164;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        dv;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_in_sync;
    logic        o_lof;
`ifdef DEMAP_FRAME_STATS_EN
    logic [15:0] o_fas_err_cnt;
    logic [15:0] o_lof_cnt;
`endif

    demap_frame_ctrl #(.MISS_LIMIT(4), .FAS_A(FAS_A), .FAS_B(FAS_B)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_line_data        (din),
        .i_line_data_valid  (dv),
        .o_frame_data       (o_frame_data),
        .o_frame_data_valid (o_frame_data_valid),
        .o_row_cnt          (o_row_cnt),
        .o_col_cnt          (o_col_cnt),
        .o_in_sync          (o_in_sync),
`ifdef DEMAP_FRAME_STATS_EN
        .o_fas_err_cnt      (o_fas_err_cnt),
        .o_lof_cnt          (o_lof_cnt),
`endif
        .o_lof              (o_lof)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          f_vcnt, f_bad, f_gapv, f_lofsum;
    logic        f_sync5, f_lof5, f_valid6;
    logic [12:0] f_rc5, f_rc6, f_rclast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic v);
        @(negedge clk);
        din = b;
        dv  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dv  = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send(8'($urandom_range(0, 245)), 1'b1);
    endtask

    // Sends nbytes of a frame (FAS byte 3 = b3); expected position derived from byte index
    task automatic send_frame(input logic [7:0] b3, input bit gap, input int nbytes);
        int r, c;
        logic [7:0] b;
        f_vcnt = 0; f_bad = 0; f_gapv = 0; f_lofsum = 0;
        f_sync5 = 1'bx; f_lof5 = 1'bx; f_valid6 = 1'bx;
        f_rc5 = '1; f_rc6 = '1; f_rclast = '1;
        for (int i = 0; i < nbytes; i++) begin
            r = i / 1041;
            c = i % 1041;
            if (i < 3)       b = FAS_A;
            else if (i == 3) b = b3;
            else if (i < 6)  b = FAS_B;
            else             b = c[7:0];
            send(b, 1'b1);
            if (o_frame_data_valid) begin
                f_vcnt++;
                if ({o_row_cnt, o_col_cnt} !== {r[1:0], c[10:0]} || o_frame_data !== b) f_bad++;
            end
            if (o_lof) f_lofsum++;
            if (i == 5) begin
                f_sync5 = o_in_sync;
                f_lof5  = o_lof;
                f_rc5   = {o_row_cnt, o_col_cnt};
            end
            if (i == 6) begin
                f_valid6 = o_frame_data_valid;
                f_rc6    = {o_row_cnt, o_col_cnt};
            end
            if (i == FRAME - 1) f_rclast = {o_row_cnt, o_col_cnt};
            if (gap) begin
                send(8'hAA, 1'b0);
                if (o_frame_data_valid) f_gapv++;
                if (o_lof) f_lofsum++;
            end
        end
    endtask

    int   acc_v, acc_lof;
    logic acc_sync;

    initial begin
        rst = 1'b1; dv = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_frame_data, o_frame_data_valid, o_row_cnt, o_col_cnt, o_in_sync, o_lof}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h5A, 1'b0);
        chk("idle_outputs", {o_frame_data_valid, o_row_cnt, o_col_cnt, o_in_sync, o_lof}, 0);

        // Clean acquisition
        send_random(20);
        send_frame(FAS_B, 1'b0, FRAME);
        chk("f1_fas_label", f_rc5, {2'd0, 11'd5});
        chk("f1_presync_insync", f_sync5, 0);
        chk("f1_no_valid", f_vcnt, 0);
        send_frame(FAS_B, 1'b0, FRAME);
        chk("f2_insync_at5", f_sync5, 1);
        chk("f2_valid_at6", f_valid6, 1);
        chk("f2_rc_at6", f_rc6, {2'd0, 11'd6});
        chk("f2_rc_last", f_rclast, {2'd3, 11'd1040});
        chk("f2_valid_count", f_vcnt, FRAME - 6);
        chk("f2_label_errors", f_bad, 0);

        // Three misses then a clean FAS: lock holds
        acc_v = 0; acc_lof = 0; acc_sync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_frame((k < 3) ? 8'h29 : FAS_B, 1'b0, FRAME);
            acc_v += f_vcnt; acc_lof += f_lofsum; acc_sync &= f_sync5;
        end
        chk("miss3_insync", acc_sync, 1);
        chk("miss3_no_lof", acc_lof, 0);
        chk("miss3_valid_count", acc_v, 4 * FRAME);

        // Four consecutive misses: LOF on the fourth
        acc_lof = 0; acc_sync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_frame(8'h29, 1'b0, FRAME);
            acc_lof += f_lofsum; acc_sync &= f_sync5;
        end
        chk("miss_pre_lof_sync", acc_sync, 1);
        chk("miss_pre_lof_nolof", acc_lof, 0);
        send_frame(8'h29, 1'b0, 12);
        chk("lof_pulse_at5", f_lof5, 1);
        chk("lof_insync_drop", f_sync5, 0);
        chk("lof_single_pulse", f_lofsum, 1);
        chk("lof_valid_count", f_vcnt, 6);
`ifdef DEMAP_FRAME_STATS_EN
        chk("stat_lof_cnt", o_lof_cnt, 1);
        chk("stat_fas_err_cnt", o_fas_err_cnt, 7);
`endif

        // PRESYNC mismatch returns to HUNT
        do_reset();
        send_random(20);
        send_frame(FAS_B, 1'b0, FRAME);
        chk("p1_fas_label", f_rc5, {2'd0, 11'd5});
        send_frame(8'h29, 1'b0, FRAME);
        chk("p2_no_sync", f_sync5, 0);
        chk("p2_no_valid", f_vcnt, 0);
        send_frame(FAS_B, 1'b0, FRAME);
        chk("p3_presync_only", f_sync5, 0);
        chk("p3_no_valid", f_vcnt, 0);
        send_frame(FAS_B, 1'b0, 10);
        chk("p4_insync", f_sync5, 1);
        chk("p4_valid_at6", f_valid6, 1);
`ifdef DEMAP_FRAME_STATS_EN
        chk("stat_presync_err", o_fas_err_cnt, 1);
`endif

        // Valid on every other cycle
        do_reset();
        send_random(20);
        send_frame(FAS_B, 1'b1, FRAME);
        chk("g1_fas_label", f_rc5, {2'd0, 11'd5});
        chk("g1_no_valid", f_vcnt, 0);
        send_frame(FAS_B, 1'b1, FRAME);
        chk("g2_insync_at5", f_sync5, 1);
        chk("g2_rc_at6", f_rc6, {2'd0, 11'd6});
        chk("g2_rc_last", f_rclast, {2'd3, 11'd1040});
        chk("g2_valid_count", f_vcnt, FRAME - 6);
        chk("g2_label_errors", f_bad, 0);
        chk("g2_gap_valid", f_gapv, 0);

        // Reset pulsed at row 2, col 500 while in SYNC
        send_frame(FAS_B, 1'b0, 2 * 1041 + 500);
        chk("r_pre_label_errors", f_bad, 0);
        chk("r_pre_valid_count", f_vcnt, 2 * 1041 + 500);
        @(negedge clk);
        rst = 1'b1; din = 8'h77; dv = 1'b1;
        @(posedge clk);
        #1;
        chk("r_outputs_zero", {o_frame_data, o_frame_data_valid, o_row_cnt, o_col_cnt, o_in_sync, o_lof}, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(FAS_B, 1'b0, FRAME);
        chk("r1_presync_only", f_sync5, 0);
        chk("r1_no_valid", f_vcnt, 0);
        send_frame(FAS_B, 1'b0, 10);
        chk("r2_insync", f_sync5, 1);
        chk("r2_valid_at6", f_valid6, 1);
`ifdef DEMAP_FRAME_STATS_EN
        chk("stat_lof_after_rst", o_lof_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
